// File: rtl/ysyx_25040111_trapctl_if.sv
// Bundle of the pipeline-side request/completion handshake and the CSR-file port pair.
// The slave view belongs to the trap sequencer; the master view to whoever drives it.
interface ysyx_25040111_trapctl_if;
    logic        inst_valid;
    logic        inst_ready;
    logic [1:0]  inst_op;
    logic [31:0] inst_pc;
    logic [11:0] inst_csr_addr;
    logic        inst_csr_wen;
    logic [31:0] inst_wdata;
    logic        done_valid;
    logic [31:0] done_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_ren;
    logic [11:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        busy;

    modport slave (
        input  inst_valid, inst_op, inst_pc, inst_csr_addr, inst_csr_wen, inst_wdata, csr_rdata,
        output inst_ready, done_valid, done_rdata, redirect_valid, redirect_pc,
               csr_wen, csr_waddr, csr_wdata, csr_ren, csr_raddr, busy
    );

    modport master (
        output inst_valid, inst_op, inst_pc, inst_csr_addr, inst_csr_wen, inst_wdata, csr_rdata,
        input  inst_ready, done_valid, done_rdata, redirect_valid, redirect_pc,
               csr_wen, csr_waddr, csr_wdata, csr_ren, csr_raddr, busy
    );
endinterface

// File: rtl/ysyx_25040111_trapctl.sv
// Trap/CSR sequencer: runs CSR accesses, ecall and mret as fixed multi-cycle walks
// over the machine-mode CSR file and returns read data or a redirect PC.
module ysyx_25040111_trapctl #(
    parameter logic [31:0] CAUSE_ECALL = 32'd11
) (
    input logic                      clock,
    input logic                      reset,
    ysyx_25040111_trapctl_if.slave   bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_ACC, S_T_EPC, S_T_CAUSE, S_T_STAT, S_T_VEC, S_R_STAT, S_R_EPC, S_DONE
    } state_t;

    localparam logic [1:0]  OP_CSR      = 2'b00;
    localparam logic [1:0]  OP_ECALL    = 2'b01;
    localparam logic [1:0]  OP_MRET     = 2'b10;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_op;
    logic [31:0] r_pc;
    logic [11:0] r_addr;
    logic        r_wen;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_redirect_pc;

    logic        w_accept;
    logic        w_csr_wen;
    logic [11:0] w_csr_waddr;
    logic [31:0] w_csr_wdata;
    logic        w_csr_ren;
    logic [11:0] w_csr_raddr;
    logic        w_done;
    logic        w_redirect;
    logic [31:0] w_mstatus_new;

    assign w_accept = bus.inst_valid && (r_state == S_IDLE) && !reset;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        w_next_state  = r_state;
        w_csr_wen     = 1'b0;
        w_csr_waddr   = '0;
        w_csr_wdata   = '0;
        w_csr_ren     = 1'b0;
        w_csr_raddr   = '0;
        w_done        = 1'b0;
        w_redirect    = 1'b0;
        w_mstatus_new = bus.csr_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (bus.inst_op)
                        OP_ECALL: w_next_state = S_T_EPC;
                        OP_MRET:  w_next_state = S_R_STAT;
                        default:  w_next_state = S_ACC;
                    endcase
                end
            end
            S_ACC: begin
                if (r_op == OP_CSR) begin
                    w_csr_ren   = 1'b1;
                    w_csr_raddr = r_addr;
                    w_csr_wen   = r_wen;
                    w_csr_waddr = r_addr;
                    w_csr_wdata = r_wdata;
                end
                w_next_state = S_DONE;
            end
            S_T_EPC: begin
                w_csr_wen    = 1'b1;
                w_csr_waddr  = CSR_MEPC;
                w_csr_wdata  = r_pc;
                w_next_state = S_T_CAUSE;
            end
            S_T_CAUSE: begin
                w_csr_wen    = 1'b1;
                w_csr_waddr  = CSR_MCAUSE;
                w_csr_wdata  = CAUSE_ECALL;
                w_next_state = S_T_STAT;
            end
            S_T_STAT: begin
                // Trap entry: stack MIE into MPIE, disable interrupts, previous mode = M.
                w_mstatus_new[7]     = bus.csr_rdata[3];
                w_mstatus_new[3]     = 1'b0;
                w_mstatus_new[12:11] = 2'b11;
                w_csr_ren    = 1'b1;
                w_csr_raddr  = CSR_MSTATUS;
                w_csr_wen    = 1'b1;
                w_csr_waddr  = CSR_MSTATUS;
                w_csr_wdata  = w_mstatus_new;
                w_next_state = S_T_VEC;
            end
            S_T_VEC: begin
                w_csr_ren    = 1'b1;
                w_csr_raddr  = CSR_MTVEC;
                w_next_state = S_DONE;
            end
            S_R_STAT: begin
                w_mstatus_new[3]     = bus.csr_rdata[7];
                w_mstatus_new[7]     = 1'b1;
                w_mstatus_new[12:11] = 2'b11;
                w_csr_ren    = 1'b1;
                w_csr_raddr  = CSR_MSTATUS;
                w_csr_wen    = 1'b1;
                w_csr_waddr  = CSR_MSTATUS;
                w_csr_wdata  = w_mstatus_new;
                w_next_state = S_R_EPC;
            end
            S_R_EPC: begin
                w_csr_ren    = 1'b1;
                w_csr_raddr  = CSR_MEPC;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_redirect   = (r_op == OP_ECALL) || (r_op == OP_MRET);
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Reset is synchronous, so gate strobes with it to keep a reset cycle from issuing a write.
    assign bus.csr_wen        = w_csr_wen && !reset;
    assign bus.csr_ren        = w_csr_ren && !reset;
    assign bus.csr_waddr      = w_csr_waddr;
    assign bus.csr_wdata      = w_csr_wdata;
    assign bus.csr_raddr      = w_csr_raddr;
    assign bus.done_valid     = w_done && !reset;
    assign bus.redirect_valid = w_redirect && !reset;
    assign bus.done_rdata     = r_rdata;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.inst_ready     = (r_state == S_IDLE) && !reset;
    assign bus.busy           = (r_state != S_IDLE);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_op          <= '0;
            r_pc          <= '0;
            r_addr        <= '0;
            r_wen         <= 1'b0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_redirect_pc <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op    <= bus.inst_op;
                r_pc    <= bus.inst_pc;
                r_addr  <= bus.inst_csr_addr;
                r_wen   <= bus.inst_csr_wen;
                r_wdata <= bus.inst_wdata;
            end
            case (r_state)
                S_ACC:   r_rdata <= (r_op == OP_CSR) ? bus.csr_rdata : '0;
                S_T_VEC: begin
                    r_rdata       <= '0;
                    r_redirect_pc <= {bus.csr_rdata[31:2], 2'b00};
                end
                S_R_EPC: begin
                    r_rdata       <= '0;
                    r_redirect_pc <= bus.csr_rdata;
                end
                default: ;
            endcase
        end
    end
endmodule
